// File: rtl/usrt_txq.sv
// usrt_txq: byte transmit queue feeding a USRT shift register.
// A circular buffer holds up to DEPTH bytes; a four-state launcher pops the
// head byte, strobes it into the shift register and waits for the busy
// handshake. A launch that never sees busy within TMO cycles is abandoned
// and flagged. Overflow and timeout events are sticky until cleared.
module usrt_txq #(
  parameter int DEPTH = 4,
  parameter int TMO   = 16
) (
  input  logic                     i_Pclk,
  input  logic                     i_Presetn,
  input  logic                     i_Wr_En,
  input  logic [7:0]               i_Wr_Data,
  input  logic                     i_Tx_Busy,
  input  logic                     i_Err_Clr,
  output logic                     o_Tx_Start,
  output logic [7:0]               o_Tx_Data,
  output logic [$clog2(DEPTH):0]   o_Count,
  output logic                     o_Full,
  output logic                     o_Empty,
  output logic                     o_Ovf,
  output logic                     o_Tmo
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TMO + 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] tmo_cnt;

  logic push;
  logic pop;
  logic tmo_hit;

  // A push into a full queue is dropped even if a pop frees a slot this cycle.
  assign push    = i_Wr_En && !o_Full;
  assign pop     = (state == IDLE) && !o_Empty && !i_Tx_Busy;
  assign tmo_hit = (state == WAIT_BUSY) && !i_Tx_Busy && (tmo_cnt == CW'(TMO - 1));

  // Status flags come straight from the registered occupancy count.
  assign o_Count = count;
  assign o_Full  = (count == (AW + 1)'(DEPTH));
  assign o_Empty = (count == '0);

  // Byte storage: written on every accepted push.
  // NOTE: storage is deliberately not reset; count and pointers alone define
  // which entries are valid, and a reset on the array blocks RAM inference.
  always_ff @(posedge i_Pclk) begin
    if (push) mem[wr_ptr] <= i_Wr_Data;
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge value of every other register.
  always_ff @(posedge i_Pclk or negedge i_Presetn) begin
    if (!i_Presetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Launcher FSM with registered strobe, data and timeout flag.
  always_ff @(posedge i_Pclk or negedge i_Presetn) begin
    if (!i_Presetn) begin
      state      <= IDLE;
      o_Tx_Start <= 1'b0;
      o_Tx_Data  <= 8'h00;
      tmo_cnt    <= '0;
      o_Tmo      <= 1'b0;
    end else begin
      // The strobe register mirrors the LAUNCH state, so it pulses one cycle.
      o_Tx_Start <= (state == LAUNCH);

      if (tmo_hit)        o_Tmo <= 1'b1;
      else if (i_Err_Clr) o_Tmo <= 1'b0;

      case (state)
        IDLE: begin
          if (pop) begin
            o_Tx_Data <= mem[rd_ptr];
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          tmo_cnt <= '0;
          state   <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (i_Tx_Busy) begin
            state <= WAIT_DONE;
          end else if (tmo_hit) begin
            // Unacknowledged byte is dropped, not re-queued.
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!i_Tx_Busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky overflow flag; a new overflow beats a simultaneous clear.
  always_ff @(posedge i_Pclk or negedge i_Presetn) begin
    if (!i_Presetn)              o_Ovf <= 1'b0;
    else if (i_Wr_En && o_Full)  o_Ovf <= 1'b1;
    else if (i_Err_Clr)          o_Ovf <= 1'b0;
  end

endmodule

// File: tb/tb_usrt_txq.sv
// tb_usrt_txq: directed, table-driven bench for usrt_txq (DEPTH=4, TMO=16).
module tb_usrt_txq;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       tx_busy;
  logic       err_clr;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       ovf;
  logic       tmo;

  int n_checks = 0;
  int n_fail   = 0;

  usrt_txq #(.DEPTH(DEPTH), .TMO(TMO)) dut (
    .i_Pclk     (clk),
    .i_Presetn  (rst_n),
    .i_Wr_En    (wr_en),
    .i_Wr_Data  (wr_data),
    .i_Tx_Busy  (tx_busy),
    .i_Err_Clr  (err_clr),
    .o_Tx_Start (tx_start),
    .o_Tx_Data  (tx_data),
    .o_Count    (count),
    .o_Full     (full),
    .o_Empty    (empty),
    .o_Ovf      (ovf),
    .o_Tmo      (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       busy;
    logic       clr;
    logic       st;
    logic [7:0] dat;
    logic [2:0] cnt;
    logic       full;
    logic       empty;
    logic       ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic cyc(input logic wr, input logic [7:0] d, input logic busy, input logic clr);
    wr_en   = wr;
    wr_data = d;
    tx_busy = busy;
    err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_start"}, tx_start, 1'b0);
    check({tag, "_data"},  tx_data,  8'h00);
    check({tag, "_count"}, count,    3'd0);
    check({tag, "_empty"}, empty,    1'b1);
    check({tag, "_full"},  full,     1'b0);
    check({tag, "_ovf"},   ovf,      1'b0);
    check({tag, "_tmo"},   tmo,      1'b0);
  endtask

  task automatic do_reset();
    wr_en = 1'b0; wr_data = 8'h00; tx_busy = 1'b0; err_clr = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t       vecs [31];
  logic [7:0] sb [$];
  int         sent;
  int         launched;
  int         busy_cnt;
  int         cycles;
  logic       pushed;
  logic [7:0] pdata;

  initial begin
    // Single byte, ordering/full, overflow with set-beats-clear, back-to-back.
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 3'd0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 3'd0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 3'd0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 3'd0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 8'hA5, 3'd1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 8'hA5, 3'd2, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 8'hA5, 3'd3, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 8'h04, 1'b1, 1'b0, 1'b0, 8'hA5, 3'd4, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 8'hA5, 3'd4, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 8'hA5, 3'd4, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5, 3'd4, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01, 3'd3, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 3'd3, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h01, 3'd3, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h01, 3'd3, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01, 3'd3, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h02, 3'd2, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h02, 3'd2, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h02, 3'd2, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h02, 3'd2, 1'b0, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h03, 3'd1, 1'b0, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h03, 3'd1, 1'b0, 1'b0, 1'b0};
    vecs[23] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h03, 3'd1, 1'b0, 1'b0, 1'b0};
    vecs[24] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h03, 3'd1, 1'b0, 1'b0, 1'b0};
    vecs[25] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h04, 3'd0, 1'b0, 1'b1, 1'b0};
    vecs[26] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h04, 3'd0, 1'b0, 1'b1, 1'b0};
    vecs[27] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h04, 3'd0, 1'b0, 1'b1, 1'b0};
    vecs[28] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h04, 3'd0, 1'b0, 1'b1, 1'b0};
    vecs[29] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h04, 3'd0, 1'b0, 1'b1, 1'b0};
    vecs[30] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h04, 3'd0, 1'b0, 1'b1, 1'b0};

    // Reset values, sampled while reset is still asserted.
    wr_en = 1'b0; wr_data = 8'h00; tx_busy = 1'b0; err_clr = 1'b0;
    rst_n = 1'b0;
    #12;
    check_reset_vals("por");
    do_reset();

    for (int i = 0; i < 31; i++) begin
      cyc(vecs[i].wr, vecs[i].d, vecs[i].busy, vecs[i].clr);
      check($sformatf("v%0d_start", i), tx_start, vecs[i].st);
      check($sformatf("v%0d_data", i),  tx_data,  vecs[i].dat);
      check($sformatf("v%0d_count", i), count,    vecs[i].cnt);
      check($sformatf("v%0d_full", i),  full,     vecs[i].full);
      check($sformatf("v%0d_empty", i), empty,    vecs[i].empty);
      check($sformatf("v%0d_ovf", i),   ovf,      vecs[i].ovf);
      check($sformatf("v%0d_tmo", i),   tmo,      1'b0);
    end

    // Timeout: launch 11 with busy held low, then 22 follows.
    do_reset();
    cyc(1'b1, 8'h11, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0);
    check("tmo_pushpop_count", count, 3'd1);
    check("tmo_first_data", tx_data, 8'h11);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check("tmo_first_start", tx_start, 1'b1);
    for (int k = 1; k < TMO; k++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      check($sformatf("tmo_wait%0d_flag", k), tmo, 1'b0);
      check($sformatf("tmo_wait%0d_start", k), tx_start, 1'b0);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check("tmo_flag_set", tmo, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check("tmo_next_data", tx_data, 8'h22);
    check("tmo_next_count", count, 3'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check("tmo_next_start", tx_start, 1'b1);
    check("tmo_sticky", tmo, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("tmo_cleared", tmo, 1'b0);

    // Simultaneous push and pop at count 2, then a wrapping stream.
    do_reset();
    cyc(1'b1, 8'h51, 1'b1, 1'b0);
    cyc(1'b1, 8'h52, 1'b1, 1'b0);
    check("pp_count_before", count, 3'd2);
    cyc(1'b1, 8'h53, 1'b0, 1'b0);
    check("pp_count_after", count, 3'd2);
    check("pp_data", tx_data, 8'h51);
    sb.push_back(8'h51); sb.push_back(8'h52); sb.push_back(8'h53);
    sent = 0; launched = 0; busy_cnt = 0; cycles = 0;
    while (launched < 3 + 3 * DEPTH && cycles < 2000) begin
      pushed = (sent < 3 * DEPTH) && !full;
      pdata  = 8'h60 + 8'(sent);
      cyc(pushed, pdata, busy_cnt > 0, 1'b0);
      if (busy_cnt > 0) busy_cnt--;
      cycles++;
      if (pushed) begin
        sb.push_back(pdata);
        sent++;
      end
      if (tx_start) begin
        if (sb.size() == 0) begin
          check("stream_unexpected_launch", tx_data, 8'h00);
          check("stream_unexpected_flag", 32'd1, 32'd0);
        end else begin
          check($sformatf("stream_launch%0d", launched), tx_data, sb.pop_front());
        end
        launched++;
        busy_cnt = 3;
      end
    end
    check("stream_finished_in_budget", cycles < 2000, 1'b1);
    repeat (6) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check("stream_drained_empty", empty, 1'b1);
    check("stream_drained_count", count, 3'd0);

    // Reset while in WAIT_DONE with three bytes queued.
    do_reset();
    cyc(1'b1, 8'h61, 1'b0, 1'b0);
    cyc(1'b1, 8'h62, 1'b0, 1'b0);
    cyc(1'b1, 8'h63, 1'b0, 1'b0);
    check("rst_pre_start", tx_start, 1'b1);
    cyc(1'b1, 8'h64, 1'b1, 1'b0);
    check("rst_pre_count", count, 3'd3);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      check($sformatf("rst_idle%0d_start", k), tx_start, 1'b0);
      check($sformatf("rst_idle%0d_empty", k), empty, 1'b1);
    end
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    check("rst_resume_count", count, 3'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_resume_data", tx_data, 8'h77);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_resume_start", tx_start, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
